pll_vga_clken_gen: RTL and testbench



---
 rtl/pll_vga_pkg.sv | 21 ++
 rtl/pll_vga_phase_acc.sv | 63 ++++++
 rtl/pll_vga_clken_gen.sv | 100 ++++++++++
 tb/tb_pll_vga_clken_gen.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/pll_vga_pkg.sv
// Shared types and helpers for the VGA clock-enable generator: the settle/lock
// state encoding, default sizing constants and the config-write validity rule.
package pll_vga_pkg;

  typedef enum logic {
    SETTLE = 1'b0,
    LOCKED = 1'b1
  } pll_state_t;

  localparam int DEF_ACC_W       = 16;
  localparam int DEF_LOCK_CYCLES = 16;

  // Operands are zero-extended to 32 bits by the caller, so ACC_W must not exceed 32.
  function automatic logic cfg_is_valid(input logic [31:0] inc,
                                        input logic [31:0] mod,
                                        input logic [31:0] chan,
                                        input logic [31:0] num_ch);
    return (mod != 32'd0) && (inc != 32'd0) && (inc <= mod) && (chan < num_ch);
  endfunction

endpackage

// File: rtl/pll_vga_phase_acc.sv
// One fractional phase-accumulator channel: emits a clock-enable at
// clk * inc/mod and a divided clock that flips on every enable.
module pll_vga_phase_acc #(
  parameter int               ACC_W   = 16,
  parameter logic [ACC_W-1:0] DEF_INC = ACC_W'(1),
  parameter logic [ACC_W-1:0] DEF_MOD = ACC_W'(2)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [ACC_W-1:0] load_inc,
  input  logic [ACC_W-1:0] load_mod,
  input  logic             clear,
  input  logic             run,
  output logic             clken,
  output logic             clkdiv
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] inc;
  logic [ACC_W-1:0] mod;
  logic [ACC_W:0]   sum;
  logic             wrap;
  logic [ACC_W-1:0] acc_next;

  // The extra sum bit keeps acc + inc from overflowing before the modulus compare.
  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    sum      = {1'b0, acc} + {1'b0, inc};
    wrap     = (sum >= {1'b0, mod});
    acc_next = sum[ACC_W-1:0];
    if (wrap) begin
      acc_next = ACC_W'(sum - {1'b0, mod});
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  // NOTE: the config registers reset to their defaults as well, so a reset reverts them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      inc    <= DEF_INC;
      mod    <= DEF_MOD;
      clken  <= 1'b0;
      clkdiv <= 1'b0;
    end else begin
      if (load) begin
        inc <= load_inc;
        mod <= load_mod;
      end
      if (run && !clear) begin
        acc    <= acc_next;
        clken  <= wrap;
        clkdiv <= clkdiv ^ wrap;
      end else begin
        acc    <= '0;
        clken  <= 1'b0;
        clkdiv <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pll_vga_clken_gen.sv
// Reprogrammable multi-channel clock-enable generator with a PLL-style lock:
// a settle FSM holds all channels idle, then releases them phase-aligned.
module pll_vga_clken_gen
  import pll_vga_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int ACC_W       = DEF_ACC_W,
  parameter int LOCK_CYCLES = DEF_LOCK_CYCLES,
  parameter int DEF_INC     = 1,
  parameter int DEF_MOD     = 2,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_chan,
  input  logic [ACC_W-1:0]  cfg_inc,
  input  logic [ACC_W-1:0]  cfg_mod,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] clken,
  output logic [NUM_CH-1:0] clkdiv,
  output logic              locked
);

  localparam int CNT_W = $clog2(LOCK_CYCLES);

  pll_state_t       state;
  pll_state_t       state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             xfer;
  logic             cfg_ok;
  logic             accept;
  logic             running;

  assign running   = (state == LOCKED);
  assign cfg_ready = running;
  assign locked    = running;
  assign xfer      = cfg_valid && cfg_ready;
  assign cfg_ok    = cfg_is_valid(32'(cfg_inc), 32'(cfg_mod), 32'(cfg_chan), 32'(NUM_CH));
  assign accept    = xfer && cfg_ok;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      SETTLE: begin
        if (cnt == CNT_W'(LOCK_CYCLES - 1)) begin
          state_next = LOCKED;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      LOCKED: begin
        // Any accepted write restarts every channel so they stay phase-aligned.
        if (accept) begin
          state_next = SETTLE;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = SETTLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= SETTLE;
      cnt     <= '0;
      cfg_err <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      cfg_err <= xfer && !cfg_ok;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pll_vga_phase_acc #(
      .ACC_W   (ACC_W),
      .DEF_INC (ACC_W'(DEF_INC)),
      .DEF_MOD (ACC_W'(DEF_MOD))
    ) u_acc (
      .clk      (refclk),
      .rst_n    (rst_n),
      .load     (accept && (cfg_chan == CH_W'(i))),
      .load_inc (cfg_inc),
      .load_mod (cfg_mod),
      .clear    (accept),
      .run      (running),
      .clken    (clken[i]),
      .clkdiv   (clkdiv[i])
    );
  end

endmodule

// File: tb/tb_pll_vga_clken_gen.sv
// Directed bench for pll_vga_clken_gen: a table of config writes with
// hand-computed clken windows, plus reset, held-valid and async-reset sequences.
module tb_pll_vga_clken_gen;

  localparam int NUM_CH      = 3;
  localparam int ACC_W       = 16;
  localparam int LOCK_CYCLES = 16;
  localparam int CH_W        = 2;

  logic              refclk = 1'b0;
  logic              rst_n;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_chan;
  logic [ACC_W-1:0]  cfg_inc;
  logic [ACC_W-1:0]  cfg_mod;
  logic              cfg_err;
  logic [NUM_CH-1:0] clken;
  logic [NUM_CH-1:0] clkdiv;
  logic              locked;

  pll_vga_clken_gen #(
    .NUM_CH      (NUM_CH),
    .ACC_W       (ACC_W),
    .LOCK_CYCLES (LOCK_CYCLES),
    .DEF_INC     (1),
    .DEF_MOD     (2)
  ) dut (
    .refclk    (refclk),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_chan  (cfg_chan),
    .cfg_inc   (cfg_inc),
    .cfg_mod   (cfg_mod),
    .cfg_err   (cfg_err),
    .clken     (clken),
    .clkdiv    (clkdiv),
    .locked    (locked)
  );

  always #5 refclk = ~refclk;

  // pat[c] is channel c's clken over the 8 cycles after relock, first sample in the MSB.
  typedef struct packed {
    logic [CH_W-1:0]        chan;
    logic [ACC_W-1:0]       inc;
    logic [ACC_W-1:0]       mod;
    logic                   ok;
    logic [NUM_CH-1:0][7:0] pat;
    logic [7:0]             div0;
  } vec_t;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_lock(output int n);
    n = 0;
    while (n < 100) begin
      @(negedge refclk);
      n++;
      if (locked === 1'b1) break;
    end
  endtask

  task automatic sample_window(output logic [NUM_CH-1:0][7:0] ce,
                               output logic [7:0] dv0, output logic lk_all);
    lk_all = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge refclk);
      for (int c = 0; c < NUM_CH; c++) ce[c][7-k] = clken[c];
      dv0[7-k] = clkdiv[0];
      lk_all   = lk_all & locked;
    end
  endtask

  task automatic write_cfg(input logic [CH_W-1:0] chan, input logic [ACC_W-1:0] inc,
                           input logic [ACC_W-1:0] mod);
    @(negedge refclk);
    cfg_valid = 1'b1;
    cfg_chan  = chan;
    cfg_inc   = inc;
    cfg_mod   = mod;
    @(negedge refclk);
    cfg_valid = 1'b0;
  endtask

  vec_t                   vecs [6];
  logic [NUM_CH-1:0][7:0] ce;
  logic [7:0]             dv0;
  logic                   lk_all;
  int                     n;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{chan: 2'd1, inc: 16'd3, mod: 16'd8, ok: 1'b1,
                pat: {8'b0101_0101, 8'b0010_0101, 8'b0101_0101}, div0: 8'b0110_0110};
    vecs[1] = '{chan: 2'd0, inc: 16'd1, mod: 16'd0, ok: 1'b0,
                pat: {8'b0101_0101, 8'b0010_0101, 8'b0101_0101}, div0: 8'h00};
    vecs[2] = '{chan: 2'd1, inc: 16'd5, mod: 16'd4, ok: 1'b0,
                pat: {8'b0101_0101, 8'b0010_0101, 8'b0101_0101}, div0: 8'h00};
    vecs[3] = '{chan: 2'd3, inc: 16'd1, mod: 16'd2, ok: 1'b0,
                pat: {8'b0101_0101, 8'b0010_0101, 8'b0101_0101}, div0: 8'h00};
    vecs[4] = '{chan: 2'd0, inc: 16'd0, mod: 16'd5, ok: 1'b0,
                pat: {8'b0101_0101, 8'b0010_0101, 8'b0101_0101}, div0: 8'h00};
    vecs[5] = '{chan: 2'd0, inc: 16'd7, mod: 16'd7, ok: 1'b1,
                pat: {8'b0101_0101, 8'b0010_0101, 8'b1111_1111}, div0: 8'b1010_1010};

    cfg_valid = 1'b0;
    cfg_chan  = '0;
    cfg_inc   = '0;
    cfg_mod   = '0;
    rst_n     = 1'b1;
    #1 rst_n  = 1'b0;

    // Reset state, held across a few clock edges.
    repeat (3) @(negedge refclk);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_ready", 32'(cfg_ready), 32'd0);
    check("rst_err", 32'(cfg_err), 32'd0);
    check("rst_clken", 32'(clken), 32'd0);
    check("rst_clkdiv", 32'(clkdiv), 32'd0);

    // First lock after reset release, then the default 1/2 pattern.
    rst_n = 1'b1;
    wait_lock(n);
    check("init_lock_edges", 32'(n), 32'd16);
    check("init_ready", 32'(cfg_ready), 32'd1);
    check("init_clken_at_lock", 32'(clken), 32'd0);
    sample_window(ce, dv0, lk_all);
    for (int c = 0; c < NUM_CH; c++) check($sformatf("init_pat%0d", c), 32'(ce[c]), 32'h55);
    check("init_div0", 32'(dv0), 32'h66);

    for (int i = 0; i < 6; i++) begin
      write_cfg(vecs[i].chan, vecs[i].inc, vecs[i].mod);
      if (vecs[i].ok) begin
        check($sformatf("v%0d_locked_drop", i), 32'(locked), 32'd0);
        check($sformatf("v%0d_ready_drop", i), 32'(cfg_ready), 32'd0);
        check($sformatf("v%0d_err", i), 32'(cfg_err), 32'd0);
        check($sformatf("v%0d_settle_clken", i), 32'(clken), 32'd0);
        wait_lock(n);
        check($sformatf("v%0d_relock_edges", i), 32'(n), 32'd16);
        sample_window(ce, dv0, lk_all);
        for (int c = 0; c < NUM_CH; c++)
          check($sformatf("v%0d_pat%0d", i, c), 32'(ce[c]), 32'(vecs[i].pat[c]));
        check($sformatf("v%0d_div0", i), 32'(dv0), 32'(vecs[i].div0));
      end else begin
        check($sformatf("v%0d_err_pulse", i), 32'(cfg_err), 32'd1);
        check($sformatf("v%0d_locked_kept", i), 32'(locked), 32'd1);
        @(negedge refclk);
        check($sformatf("v%0d_err_clear", i), 32'(cfg_err), 32'd0);
        sample_window(ce, dv0, lk_all);
        check($sformatf("v%0d_lock_window", i), 32'(lk_all), 32'd1);
        for (int c = 0; c < NUM_CH; c++)
          check($sformatf("v%0d_pulses%0d", i, c), 32'($countones(ce[c])),
                32'($countones(vecs[i].pat[c])));
      end
    end

    // cfg_valid held from a locked write through the whole settle: the second
    // write is accepted only on the first cycle after relock.
    @(negedge refclk);
    cfg_valid = 1'b1;
    cfg_chan  = 2'd0;
    cfg_inc   = 16'd1;
    cfg_mod   = 16'd4;
    @(negedge refclk);
    check("hold_first_accept", 32'(locked), 32'd0);
    wait_lock(n);
    check("hold_settle_edges", 32'(n), 32'd16);
    check("hold_ready_at_lock", 32'(cfg_ready), 32'd1);
    @(negedge refclk);
    cfg_valid = 1'b0;
    check("hold_second_accept", 32'(locked), 32'd0);
    wait_lock(n);
    check("hold_relock_edges", 32'(n), 32'd16);
    sample_window(ce, dv0, lk_all);
    check("hold_pat0", 32'(ce[0]), 32'h11);
    check("hold_pat1", 32'(ce[1]), 32'h25);
    check("hold_pat2", 32'(ce[2]), 32'h55);

    // Asynchronous reset between edges while clken[0] is high.
    n = 0;
    while (n < 8 && clken[0] !== 1'b1) begin
      @(negedge refclk);
      n++;
    end
    check("async_pre_clken0", 32'(clken[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_locked", 32'(locked), 32'd0);
    check("async_ready", 32'(cfg_ready), 32'd0);
    check("async_clken", 32'(clken), 32'd0);
    check("async_clkdiv", 32'(clkdiv), 32'd0);
    #20;
    @(negedge refclk);
    rst_n = 1'b1;
    wait_lock(n);
    check("async_relock_edges", 32'(n), 32'd16);
    sample_window(ce, dv0, lk_all);
    for (int c = 0; c < NUM_CH; c++) check($sformatf("async_pat%0d", c), 32'(ce[c]), 32'h55);
    check("async_div0", 32'(dv0), 32'h66);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
